// File: rtl/pid_loop_sequencer_if.sv
// ADC / PID-core / DAC handshake bundle of the PID loop sequencer.
// master = sequencer side, slave = converter and PID-core side.
interface pid_loop_sequencer_if #(parameter int W = 15);
  logic              adc_req;
  logic              adc_valid;
  logic signed [W:0] adc_data;
  logic signed [W:0] e_out;
  logic              pid_step;
  logic signed [W:0] u_in;
  logic              dac_wr;
  logic signed [W:0] dac_data;
  logic              dac_ready;

  modport master (
    output adc_req, e_out, pid_step, dac_wr, dac_data,
    input  adc_valid, adc_data, u_in, dac_ready
  );

  modport slave (
    input  adc_req, e_out, pid_step, dac_wr, dac_data,
    output adc_valid, adc_data, u_in, dac_ready
  );
endinterface

// File: rtl/pid_loop_sequencer.sv
// Control-period scheduler for the incremental PID core: ADC fetch, saturated
// error, PID strobe, output clamp and DAC write once every PERIOD clocks.
module pid_loop_sequencer #(
  parameter int                W       = 15,
  parameter int                PERIOD  = 2500,
  parameter int                ADC_TMO = 64,
  parameter int                PID_LAT = 2,
  parameter logic signed [W:0] U_MIN   = 16'sh0300,
  parameter logic signed [W:0] U_MAX   = 16'sh7FFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic signed [W:0]    setpoint,
  pid_loop_sequencer_if.master bus,
  output logic                 busy,
  output logic                 fault,
  output logic [7:0]           overrun_cnt
);
  localparam int CW   = $clog2(PERIOD);
  localparam int TMAX = (ADC_TMO > PID_LAT) ? ADC_TMO : PID_LAT;
  localparam int TW   = $clog2(TMAX + 1);

  // IDLE off | WAIT period timer | CAPTURE adc fetch | STEP pid strobe | HOLD pid latency | DAC output write
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CAPTURE, S_STEP, S_HOLD, S_DAC
  } state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [TW-1:0]       tmr, tmr_val;
  logic                tmr_load, tick, en_q;
  logic                e_ld, dac_ld, tmo;
  logic                adc_req, pid_step, dac_wr;
  logic signed [W:0]   e_q, dac_q, e_sat, u_clamp, u_s, adc_s;
  logic signed [W+1:0] diff;

  assign u_s   = bus.u_in;
  assign adc_s = bus.adc_data;
  assign diff  = {setpoint[W], setpoint} - {adc_s[W], adc_s};

  always_comb begin
    e_sat = diff[W:0];
    if (diff[W+1] != diff[W])
      e_sat = diff[W+1] ? {1'b1, {W{1'b0}}} : {1'b0, {W{1'b1}}};
  end

  always_comb begin
    u_clamp = u_s;
    if (u_s < U_MIN)
      u_clamp = U_MIN;
    else if (u_s > U_MAX)
      u_clamp = U_MAX;
  end

  assign tick = enable && (state != S_IDLE) && (cnt == CW'(PERIOD - 1));

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    e_ld     = 1'b0;
    dac_ld   = 1'b0;
    tmo      = 1'b0;
    adc_req  = 1'b0;
    pid_step = 1'b0;
    dac_wr   = 1'b0;
    busy     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (!enable) begin
          state_nx = S_IDLE;
        end else if (tick) begin
          state_nx = S_CAPTURE;
          tmr_load = 1'b1;
          tmr_val  = TW'(ADC_TMO - 1);
        end
      end
      S_CAPTURE: begin
        adc_req = 1'b1;
        busy    = 1'b1;
        // a sample arriving on the last allowed cycle still beats the timeout
        if (!enable) begin
          state_nx = S_IDLE;
        end else if (bus.adc_valid) begin
          e_ld     = 1'b1;
          state_nx = S_STEP;
        end else if (tmr == '0) begin
          tmo      = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_STEP: begin
        pid_step = 1'b1;
        busy     = 1'b1;
        if (!enable) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_HOLD;
          tmr_load = 1'b1;
          tmr_val  = TW'(PID_LAT - 1);
        end
      end
      S_HOLD: begin
        busy = 1'b1;
        if (!enable) begin
          state_nx = S_IDLE;
        end else if (tmr == '0) begin
          dac_ld   = 1'b1;
          state_nx = S_DAC;
        end
      end
      S_DAC: begin
        dac_wr = 1'b1;
        busy   = 1'b1;
        if (bus.dac_ready) state_nx = enable ? S_WAIT : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tmr         <= '0;
      en_q        <= 1'b0;
      e_q         <= '0;
      dac_q       <= '0;
      fault       <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state <= state_nx;
      en_q  <= enable;

      if (state == S_IDLE)
        cnt <= '0;
      else if (enable)
        cnt <= tick ? '0 : cnt + 1'b1;

      if (tmr_load)
        tmr <= tmr_val;
      else if (tmr != '0)
        tmr <= tmr - 1'b1;

      if (tmo)
        fault <= 1'b1;
      else if (enable && !en_q)
        fault <= 1'b0;

      // a tick that finds the loop still busy is dropped and counted
      if (tick && (state != S_WAIT) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;

      if (e_ld)   e_q   <= e_sat;
      if (dac_ld) dac_q <= u_clamp;
    end
  end

  assign bus.adc_req  = adc_req;
  assign bus.pid_step = pid_step;
  assign bus.dac_wr   = dac_wr;
  assign bus.e_out    = e_q;
  assign bus.dac_data = dac_q;
endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Bench for pid_loop_sequencer: deadline-based loop model checked every cycle,
// directed handshake / saturation / timeout / overrun cases plus random traffic.
module tb_pid_loop_sequencer;
  localparam int PER     = 16;
  localparam int ADC_TMO = 64;
  localparam int PID_LAT = 2;
  localparam int M_IDLE = 0, M_WAIT = 1, M_ADC = 2, M_PID = 3, M_DAC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic signed [15:0] setpoint = '0;
  logic busy, fault;
  logic [7:0] overrun_cnt;

  pid_loop_sequencer_if #(.W(15)) bus ();

  pid_loop_sequencer #(.PERIOD(PER), .ADC_TMO(ADC_TMO), .PID_LAT(PID_LAT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .setpoint(setpoint), .bus(bus),
    .busy(busy), .fault(fault), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: loop phase plus absolute-cycle deadlines
  int mc = 0;
  bit m_live = 0;
  int m_mode = M_IDLE;
  int m_pos = 0;
  int m_cap_end = 0;
  int m_step_at = 0;
  int m_ovr = 0;
  bit m_fault = 0;
  bit m_en_q = 0;
  logic signed [15:0] m_e = '0;
  logic signed [15:0] m_dac = '0;

  function automatic logic signed [15:0] sat_err(input logic signed [15:0] sp, input logic signed [15:0] ad);
    int d;
    d = int'(sp) - int'(ad);
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return 16'(d);
  endfunction

  function automatic logic signed [15:0] clamp_u(input logic signed [15:0] u);
    int v;
    v = int'(u);
    if (v < 768) v = 768;
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  task automatic model_step();
    bit tk;
    int old;
    if (reset) begin
      m_mode = M_IDLE; m_pos = 0; m_e = '0; m_dac = '0;
      m_fault = 0; m_ovr = 0; m_en_q = 0; m_live = 1;
      mc++;
      return;
    end
    old = m_mode;
    tk = (m_mode != M_IDLE) && enable && (m_pos == PER - 1);
    if (enable && !m_en_q) m_fault = 0;
    if (tk && m_mode != M_WAIT && m_ovr < 255) m_ovr++;
    case (m_mode)
      M_IDLE: if (enable) m_mode = M_WAIT;
      M_WAIT: begin
        if (!enable) m_mode = M_IDLE;
        else if (tk) begin m_mode = M_ADC; m_cap_end = mc + ADC_TMO; end
      end
      M_ADC: begin
        if (!enable) m_mode = M_IDLE;
        else if (bus.adc_valid) begin
          m_e = sat_err(setpoint, bus.adc_data);
          m_mode = M_PID;
          m_step_at = mc + 1;
        end else if (mc == m_cap_end) begin
          m_fault = 1;
          m_mode = M_WAIT;
        end
      end
      M_PID: begin
        if (!enable) m_mode = M_IDLE;
        else if (mc == m_step_at + PID_LAT) begin
          m_dac = clamp_u(bus.u_in);
          m_mode = M_DAC;
        end
      end
      default: if (bus.dac_ready) m_mode = enable ? M_WAIT : M_IDLE;
    endcase
    if (old == M_IDLE) m_pos = 0;
    else if (enable) m_pos = (m_pos + 1) % PER;
    m_en_q = enable;
    mc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, mc, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("adc_req", bus.adc_req, m_mode == M_ADC);
      chk("pid_step", bus.pid_step, (m_mode == M_PID) && (mc == m_step_at));
      chk("dac_wr", bus.dac_wr, m_mode == M_DAC);
      chk("busy", busy, m_mode >= M_ADC);
      chk("fault", fault, m_fault);
      chk("overrun_cnt", overrun_cnt, m_ovr);
      chk("e_out", bus.e_out, m_e);
      chk("dac_data", bus.dac_data, m_dac);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; setpoint = '0;
    bus.adc_valid = 0; bus.adc_data = '0; bus.u_in = '0; bus.dac_ready = 0;
    repeat (3) step();
    reset = 0;
  endtask

  task automatic wait_req(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (bus.adc_req) begin ok = 1; break; end
    end
  endtask

  task automatic wait_wr(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (bus.dac_wr) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic run_period(input logic signed [15:0] sp, input logic signed [15:0] ad,
                            input logic signed [15:0] uu, output logic signed [15:0] e_seen,
                            output logic signed [15:0] d_seen, output bit ok);
    bit ok2;
    setpoint = sp; bus.adc_data = ad; bus.u_in = uu;
    bus.adc_valid = 0; bus.dac_ready = 0; enable = 1;
    e_seen = 'x; d_seen = 'x;
    wait_req(40, ok);
    if (!ok) return;
    bus.adc_valid = 1;
    step();
    bus.adc_valid = 0;
    wait_wr(8, ok2);
    ok = ok2;
    e_seen = bus.e_out;
    d_seen = bus.dac_data;
    bus.dac_ready = 1;
    step();
    bus.dac_ready = 0;
  endtask

  logic signed [15:0] tv_sp [6] = '{16'sh7FFF, 16'sh8000, 16'sh0100, 16'shFFFB, 16'sh1000, 16'sh0000};
  logic signed [15:0] tv_ad [6] = '{16'sh8000, 16'sh0001, 16'sh0050, 16'sh0003, 16'sh2000, 16'sh8000};
  logic signed [15:0] tv_u  [6] = '{16'sh0100, 16'sh1234, 16'shF000, 16'sh7FFF, 16'sh02FF, 16'sh0300};
  logic signed [15:0] tv_e  [6] = '{16'sh7FFF, 16'sh8000, 16'sh00B0, 16'shFFF8, 16'shF000, 16'sh7FFF};
  logic signed [15:0] tv_d  [6] = '{16'sh0300, 16'sh1234, 16'sh0300, 16'sh7FFF, 16'sh0300, 16'sh0300};

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: got time limit expected bench completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int age, nsteps, nwr, last_step, first_step, r0, n, nstep;
    bit ok, stable;
    logic signed [15:0] e_s, d_s, d0;
    int pv, pr;

    do_reset();
    chk("rst_adc_req", bus.adc_req, 0);
    chk("rst_pid_step", bus.pid_step, 0);
    chk("rst_dac_wr", bus.dac_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_e_out", bus.e_out, 0);
    chk("rst_dac_data", bus.dac_data, 0);

    // steady loop: ADC answers after 3 wait cycles, DAC ready at once
    enable = 1; bus.dac_ready = 1; age = 0; nsteps = 0; nwr = 0;
    last_step = -1; first_step = -1; r0 = mc;
    for (int i = 0; i < 100; i++) begin
      step();
      age = bus.adc_req ? age + 1 : 0;
      bus.adc_valid = (age == 4);
      setpoint = 16'($urandom); bus.adc_data = 16'($urandom); bus.u_in = 16'($urandom);
      if (bus.pid_step) begin
        if (last_step >= 0) chk("step_interval", mc - last_step, PER);
        else first_step = mc - r0;
        last_step = mc;
        nsteps++;
      end
      if (bus.dac_wr) begin
        chk("step_to_wr", mc - last_step, 3);
        nwr++;
      end
    end
    chk("first_step_latency", first_step, 21);
    chk("steps_in_window", nsteps, 5);
    chk("writes_in_window", nwr, 5);

    // error saturation and output clamp
    do_reset();
    for (int k = 0; k < 6; k++) begin
      run_period(tv_sp[k], tv_ad[k], tv_u[k], e_s, d_s, ok);
      chk("period_handshake", ok, 1);
      chk("e_out_value", e_s, tv_e[k]);
      chk("dac_data_value", d_s, tv_d[k]);
      if (k < 2) begin
        chk("model_e", m_e, tv_e[k]);
        chk("model_dac", m_dac, tv_d[k]);
      end
    end

    // ADC timeout
    do_reset();
    enable = 1;
    wait_req(40, ok);
    chk("tmo_req_seen", ok, 1);
    n = 0; nstep = 0;
    while (bus.adc_req && n < 100) begin
      n++;
      step();
      if (bus.pid_step) nstep++;
    end
    chk("tmo_req_len", n, 64);
    chk("tmo_fault", fault, 1);
    chk("tmo_no_step", nstep, 0);
    chk("tmo_overrun", overrun_cnt, 4);
    wait_req(40, ok);
    chk("tmo_retry", ok, 1);
    enable = 0;
    step(); step();
    enable = 1;
    step();
    chk("fault_clear", fault, 0);

    // DAC stalled 40 cycles
    do_reset();
    enable = 1; bus.u_in = 16'sh1234; setpoint = 16'sh0010; bus.adc_data = 16'sh0004;
    wait_req(40, ok);
    chk("stall_req_seen", ok, 1);
    bus.adc_valid = 1;
    step();
    bus.adc_valid = 0;
    wait_wr(8, ok);
    chk("stall_wr_seen", ok, 1);
    d0 = bus.dac_data;
    stable = 1;
    for (int i = 0; i < 40; i++) begin
      if (!bus.dac_wr || bus.dac_data != d0) stable = 0;
      step();
    end
    bus.dac_ready = 1;
    step();
    bus.dac_ready = 0;
    chk("stall_dac_value", d0, 16'sh1234);
    chk("stall_single_write", stable, 1);
    chk("stall_released", bus.dac_wr, 0);
    chk("stall_overrun", overrun_cnt, 2);
    chk("model_overrun", m_ovr, 2);

    // reset in the middle of a DAC write
    wait_req(40, ok);
    bus.adc_valid = 1;
    step();
    bus.adc_valid = 0;
    wait_wr(8, ok);
    chk("rstdac_wr_seen", ok, 1);
    reset = 1;
    step();
    reset = 0;
    chk("rstdac_dac_wr", bus.dac_wr, 0);
    chk("rstdac_busy", busy, 0);
    chk("rstdac_overrun", overrun_cnt, 0);
    chk("rstdac_dac_data", bus.dac_data, 0);
    chk("rstdac_e_out", bus.e_out, 0);

    // enable dropped during HOLD, then counter restarts from zero
    setpoint = 16'sh0200; bus.adc_data = 16'sh0100;
    wait_req(40, ok);
    bus.adc_valid = 1;
    step();
    bus.adc_valid = 0;
    step();
    enable = 0;
    step();
    chk("hold_drop_busy", busy, 0);
    chk("hold_drop_dac_wr", bus.dac_wr, 0);
    chk("hold_drop_e_out", bus.e_out, 16'sh0100);
    step(); step();
    enable = 1;
    n = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (bus.adc_req) begin ok = 1; break; end
    end
    chk("restart_seen", ok, 1);
    chk("restart_latency", n, 17);

    // overrun counter saturation with a silent ADC
    do_reset();
    enable = 1;
    repeat (5200) step();
    chk("overrun_saturate", overrun_cnt, 255);

    // randomized traffic
    do_reset();
    enable = 1;
    for (int s = 0; s < 6; s++) begin
      pv = (s == 2) ? 0 : 10 + 15 * s;
      pr = 20 + 12 * s;
      for (int i = 0; i < 700; i++) begin
        step();
        reset = ($urandom_range(0, 999) < 2);
        if ($urandom_range(0, 999) < 6) enable = ~enable;
        setpoint = 16'($urandom);
        bus.adc_data = 16'($urandom);
        bus.u_in = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 2000));
        bus.adc_valid = ($urandom_range(0, 99) < pv);
        bus.dac_ready = ($urandom_range(0, 99) < pr);
      end
    end
    reset = 0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
